// File: rtl/rr_arb_mux_if.sv
// ----------------------------------------------------------------------------
// rr_arb_mux_if
//   Bundles the channel-side and consumer-side signals of rr_arb_mux.
//   slave  modport : the arbiter's view (channels and control in, grants and
//                    registered output out).
//   master modport : the environment's view (producers, control, consumer).
//
//   in_data    NUM_CH*WIDTH  channel i data = in_data[i*WIDTH +: WIDTH]
//   in_valid   NUM_CH        channel i holds data
//   in_ready   NUM_CH        channel i transfer accepted this cycle
//   force_en   1             bypass arbitration, only force_sel is eligible
//   force_sel  SELW          forced channel index
//   out_data   WIDTH         registered selected data
//   out_ch     SELW          channel that produced out_data
//   out_valid  1             out_data/out_ch valid
//   out_ready  1             consumer accepts out_data
// ----------------------------------------------------------------------------
interface rr_arb_mux_if #(
   parameter int WIDTH  = 8,
   parameter int NUM_CH = 4
);
   localparam int SELW = $clog2(NUM_CH);

   logic [NUM_CH*WIDTH-1:0] in_data;
   logic [NUM_CH-1:0]       in_valid;
   logic [NUM_CH-1:0]       in_ready;
   logic                    force_en;
   logic [SELW-1:0]         force_sel;
   logic [WIDTH-1:0]        out_data;
   logic [SELW-1:0]         out_ch;
   logic                    out_valid;
   logic                    out_ready;

   modport slave (
      input  in_data, in_valid, force_en, force_sel, out_ready,
      output in_ready, out_data, out_ch, out_valid
   );

   modport master (
      output in_data, in_valid, force_en, force_sel, out_ready,
      input  in_ready, out_data, out_ch, out_valid
   );
endinterface

// File: rtl/rr_arb_mux.sv
// ----------------------------------------------------------------------------
// rr_arb_mux
//   N-channel, W-bit arbitrated multiplexer with one registered output stage.
//   One valid/ready channel is granted per cycle, either round-robin
//   (MODE=0), fixed priority with lowest index winning (MODE=1), or forced
//   through force_en/force_sel. The granted word is captured into the output
//   register and presented with the index of the channel it came from.
//
//   Parameters
//     WIDTH   data width per channel (>=1)
//     NUM_CH  number of input channels (>=2)
//     MODE    0 = round-robin, 1 = fixed priority
//
//   Ports
//     clk     rising-edge clock
//     rst_n   asynchronous active-low reset
//     bus     rr_arb_mux_if.slave (channel inputs, grants, registered output)
// ----------------------------------------------------------------------------
module rr_arb_mux #(
   parameter int WIDTH  = 8,
   parameter int NUM_CH = 4,
   parameter int MODE   = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   rr_arb_mux_if.slave  bus
);

   localparam int              SELW    = $clog2(NUM_CH);
   localparam logic [SELW-1:0] LAST_CH = SELW'(NUM_CH - 1);

   logic [NUM_CH-1:0] grant;
   logic [SELW-1:0]   gnt_id;
   logic              gnt_any;
   logic              load;
   logic              xfer;

   logic [WIDTH-1:0]  out_data_q,  out_data_d;
   logic [SELW-1:0]   out_ch_q,    out_ch_d;
   logic              out_valid_q, out_valid_d;
   logic [SELW-1:0]   ptr_q,       ptr_d;

   // Grant selection. The priority loops run from the least to the most
   // preferred candidate so that the last match overwrites earlier ones.
   always_comb begin : grant_logic
      int idx;
      grant   = '0;
      gnt_id  = '0;
      gnt_any = 1'b0;
      idx     = 0;
      if (bus.force_en) begin
         // An out-of-range force_sel matches no channel and yields no grant.
         for (int i = 0; i < NUM_CH; i++) begin
            if (bus.force_sel == SELW'(i) && bus.in_valid[i]) begin
               grant[i] = 1'b1;
               gnt_id   = SELW'(i);
               gnt_any  = 1'b1;
            end
         end
      end else if (MODE == 1) begin
         for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (bus.in_valid[i]) begin
               grant    = '0;
               grant[i] = 1'b1;
               gnt_id   = SELW'(i);
               gnt_any  = 1'b1;
            end
         end
      end else begin
         // Scan ptr, ptr+1, ... with wrap; offset 0 (the pointer) is preferred.
         for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (bus.in_valid[idx]) begin
               grant      = '0;
               grant[idx] = 1'b1;
               gnt_id     = SELW'(idx);
               gnt_any    = 1'b1;
            end
         end
      end
   end

   // The output register can take a new word when empty or draining now.
   assign load = !out_valid_q || bus.out_ready;
   assign xfer = gnt_any && load;

   // in_ready is held low throughout reset even though load is high then.
   assign bus.in_ready = (xfer && rst_n) ? grant : '0;

   always_comb begin : next_state
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      out_valid_d = out_valid_q;
      ptr_d       = ptr_q;
      if (xfer) begin
         out_data_d  = bus.in_data[int'(gnt_id)*WIDTH +: WIDTH];
         out_ch_d    = gnt_id;
         out_valid_d = 1'b1;
         // Forced transfers do not disturb the round-robin order.
         if (!bus.force_en && MODE == 0) begin
            ptr_d = (gnt_id == LAST_CH) ? '0 : gnt_id + 1'b1;
         end
      end else if (bus.out_ready) begin
         // Drain: data and channel id keep their last value.
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_ch_q    <= '0;
         out_valid_q <= 1'b0;
         ptr_q       <= '0;
      end else begin
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         out_valid_q <= out_valid_d;
         ptr_q       <= ptr_d;
      end
   end

   assign bus.out_data  = out_data_q;
   assign bus.out_ch    = out_ch_q;
   assign bus.out_valid = out_valid_q;

endmodule
